// File: rtl/ssd_pattern_encoder.sv
// rtl/ssd_pattern_encoder.sv - segment pattern sync, glitch filter, digit encode and mod-10 order check
module ssd_pattern_encoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             freq,
  input  logic             rst_n,
  input  logic [14:0]      D_ssd,
  input  logic             clr_err,
  output logic [3:0]       d,
  output logic             d_valid,
  output logic             new_digit,
  output logic             unknown,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [7:0]  STABLE = 8'(STABLE_CYCLES);
  localparam logic [14:0] PAT_E  = 15'b0111_0000_1111_111;

  typedef enum logic {IDLE, TRACK} state_t;

  logic [14:0]      s1_q, s2_q, s3_q, last_pat_q, acc_pat_q;
  logic [14:0]      last_pat_d, acc_pat_d;
  logic [7:0]       stab_cnt_q, stab_cnt_d;
  logic             have_last_q, have_last_d, acc_q, acc_d;
  state_t           state_q, state_d;
  logic [3:0]       prev_q, prev_d, d_q, d_d;
  logic             d_valid_q, d_valid_d, new_digit_q, new_digit_d;
  logic             unknown_q, unknown_d, seq_err_q, seq_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       dig, nxt;
  logic             is_digit, is_e, changed;

  always_comb begin
    dig      = 4'hF;
    is_digit = 1'b1;
    is_e     = 1'b0;
    case (acc_pat_q)
      15'b0000_0011_1111_111: dig = 4'd0;
      15'b1111_1111_1011_011: dig = 4'd1;
      15'b0010_0100_1111_111: dig = 4'd2;
      15'b0000_1100_1111_111: dig = 4'd3;
      15'b1001_1000_1111_111: dig = 4'd4;
      15'b0100_1000_1111_111: dig = 4'd5;
      15'b0100_0000_1111_111: dig = 4'd6;
      15'b0001_1111_1111_111: dig = 4'd7;
      15'b0000_0000_1111_111: dig = 4'd8;
      15'b0000_1000_1111_111: dig = 4'd9;
      PAT_E: begin
        dig      = 4'hE;
        is_digit = 1'b0;
        is_e     = 1'b1;
      end
      default: is_digit = 1'b0;
    endcase
  end

  always_comb begin
    changed    = (s2_q != s3_q);
    stab_cnt_d = stab_cnt_q;
    if (changed)                  stab_cnt_d = 8'd1;
    else if (stab_cnt_q < STABLE) stab_cnt_d = stab_cnt_q + 8'd1;

    // A change always restarts the count, so with STABLE_CYCLES=1 it is itself a transition.
    acc_d = (stab_cnt_d == STABLE) && (changed || stab_cnt_q != STABLE) &&
            (!have_last_q || s2_q != last_pat_q);
    acc_pat_d   = acc_d ? s2_q : acc_pat_q;
    last_pat_d  = acc_d ? s2_q : last_pat_q;
    have_last_d = have_last_q | acc_d;

    nxt         = (prev_q == 4'd9) ? 4'd0 : prev_q + 4'd1;
    new_digit_d = acc_q;
    unknown_d   = acc_q && !is_digit && !is_e;
    seq_err_d   = acc_q && is_digit && (state_q == TRACK) && (dig != nxt);
    d_d         = acc_q ? dig : d_q;
    d_valid_d   = acc_q ? is_digit : d_valid_q;

    state_d = state_q;
    prev_d  = prev_q;
    if (acc_q) begin
      if (is_digit) begin
        state_d = TRACK;
        prev_d  = dig;
      end else begin
        state_d = IDLE;
      end
    end

    err_cnt_d = err_cnt_q;
    if (clr_err)                       err_cnt_d = '0;
    else if (seq_err_d && ~&err_cnt_q) err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  always_ff @(posedge freq or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= 15'h7FFF;
      s2_q        <= 15'h7FFF;
      s3_q        <= 15'h7FFF;
      stab_cnt_q  <= 8'd0;
      last_pat_q  <= 15'h7FFF;
      have_last_q <= 1'b0;
      acc_q       <= 1'b0;
      acc_pat_q   <= 15'h7FFF;
      state_q     <= IDLE;
      prev_q      <= 4'd0;
      d_q         <= 4'hF;
      d_valid_q   <= 1'b0;
      new_digit_q <= 1'b0;
      unknown_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      s1_q        <= D_ssd;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      stab_cnt_q  <= stab_cnt_d;
      last_pat_q  <= last_pat_d;
      have_last_q <= have_last_d;
      acc_q       <= acc_d;
      acc_pat_q   <= acc_pat_d;
      state_q     <= state_d;
      prev_q      <= prev_d;
      d_q         <= d_d;
      d_valid_q   <= d_valid_d;
      new_digit_q <= new_digit_d;
      unknown_q   <= unknown_d;
      seq_err_q   <= seq_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign d         = d_q;
  assign d_valid   = d_valid_q;
  assign new_digit = new_digit_q;
  assign unknown   = unknown_q;
  assign seq_err   = seq_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ssd_pattern_encoder.sv
// tb/tb_ssd_pattern_encoder.sv - scoreboard bench for ssd_pattern_encoder
module tb_ssd_pattern_encoder;

  localparam int SC = 4;

  logic        freq, rst_n, clr_err;
  logic [14:0] D_ssd;
  logic [3:0]  d;
  logic        d_valid, new_digit, unknown, seq_err;
  logic [7:0]  err_cnt;

  ssd_pattern_encoder #(.STABLE_CYCLES(SC), .ERR_W(8)) dut (
    .freq(freq), .rst_n(rst_n), .D_ssd(D_ssd), .clr_err(clr_err),
    .d(d), .d_valid(d_valid), .new_digit(new_digit), .unknown(unknown),
    .seq_err(seq_err), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [3:0] d;
    logic       v;
    logic       unk;
    logic       seq;
    logic [7:0] err;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [14:0] tbl[10];
  logic [14:0] pat_e, pat_x;
  int          n_tests = 0;
  int          n_fail  = 0;

  logic        m_have, m_track;
  logic [14:0] m_last;
  int          m_prev, m_err;

  initial freq = 1'b0;
  always #5 freq = ~freq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_have  = 1'b0;
    m_track = 1'b0;
    m_last  = 15'h7FFF;
    m_prev  = 0;
    m_err   = 0;
  endtask

  task automatic expect_accept(input logic [14:0] pat);
    exp_t e;
    int   dg;
    dg = -1;
    for (int i = 0; i < 10; i++) if (pat == tbl[i]) dg = i;
    e.seq = 1'b0;
    e.unk = 1'b0;
    if (dg >= 0) begin
      e.d = 4'(dg);
      e.v = 1'b1;
      e.seq = m_track && (dg != (m_prev + 1) % 10);
      m_prev  = dg;
      m_track = 1'b1;
      if (e.seq && m_err < 255) m_err++;
    end else begin
      e.d = (pat == pat_e) ? 4'hE : 4'hF;
      e.v = 1'b0;
      e.unk = (pat != pat_e);
      m_track = 1'b0;
    end
    e.err  = 8'(m_err);
    m_last = pat;
    m_have = 1'b1;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [14:0] pat, input int n);
    D_ssd = pat;
    if (n >= SC && (!m_have || pat != m_last)) expect_accept(pat);
    repeat (n) @(posedge freq);
    #1;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge freq);
    #1;
    clr_err = 1'b0;
    m_err   = 0;
    chk("clr_err", err_cnt, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_d"}, d, 4'hF);
    chk({tag, "_d_valid"}, d_valid, 0);
    chk({tag, "_new_digit"}, new_digit, 0);
    chk({tag, "_unknown"}, unknown, 0);
    chk({tag, "_seq_err"}, seq_err, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  always @(negedge freq) begin
    if (rst_n) begin
      if (new_digit) begin
        if (sbq.size() == 0) begin
          chk("spurious_new_digit", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("d", d, mon_e.d);
          chk("d_valid", d_valid, mon_e.v);
          chk("unknown", unknown, mon_e.unk);
          chk("seq_err", seq_err, mon_e.seq);
          chk("err_cnt", err_cnt, mon_e.err);
        end
      end else if (unknown || seq_err) begin
        chk("stray_pulse", 1, 0);
      end
    end
  end

  initial begin
    int lat;
    tbl[0] = 15'b0000_0011_1111_111;
    tbl[1] = 15'b1111_1111_1011_011;
    tbl[2] = 15'b0010_0100_1111_111;
    tbl[3] = 15'b0000_1100_1111_111;
    tbl[4] = 15'b1001_1000_1111_111;
    tbl[5] = 15'b0100_1000_1111_111;
    tbl[6] = 15'b0100_0000_1111_111;
    tbl[7] = 15'b0001_1111_1111_111;
    tbl[8] = 15'b0000_0000_1111_111;
    tbl[9] = 15'b0000_1000_1111_111;
    pat_e  = 15'b0111_0000_1111_111;
    pat_x  = 15'h1234;
    model_reset();

    rst_n   = 1'b0;
    clr_err = 1'b0;
    D_ssd   = tbl[0];
    #12;
    chk_reset("reset");

    expect_accept(tbl[0]);
    @(negedge freq);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge freq);
      #1;
      if (new_digit && lat == 0) lat = i;
    end
    chk("first_latency", lat, SC + 3);
    drive(tbl[0], 20);

    drive(pat_e, 10);
    for (int i = 0; i < 12; i++) drive(tbl[i % 10], 10);
    chk("count_err_cnt", err_cnt, 0);

    drive(pat_e, 10);
    drive(tbl[3], 10);
    drive(tbl[5], 10);
    drive(tbl[6], 10);
    chk("order_err_cnt", err_cnt, 1);
    pulse_clr();

    drive(pat_e, 10);
    drive(tbl[4], 10);
    drive(tbl[7], 2);
    drive(tbl[4], 10);
    chk("glitch_d", d, 4);
    drive(tbl[7], 4);
    drive(tbl[4], 10);
    chk("glitch4_err_cnt", err_cnt, 2);

    drive(pat_x, 10);
    drive(tbl[7], 10);
    drive(pat_e, 10);
    chk("e_fill_d", d, 4'hE);

    pulse_clr();
    drive(tbl[3], 8);
    for (int i = 0; i < 258; i++) drive(tbl[(i % 2 == 0) ? 5 : 3], 8);
    chk("sat_err_cnt", err_cnt, 255);

    drive(tbl[3], 12);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("async_reset");
    sbq.delete();
    model_reset();
    expect_accept(tbl[3]);
    #2;
    rst_n = 1'b1;
    repeat (15) @(posedge freq);
    #1;

    repeat (5) @(posedge freq);
    chk("drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
